simon_data_in: RTL
==================

# simon_data_in

Input packet unpacker for the SIMON datapath, directly upstream of the cipher core and mirror of the output packer. It accepts one byte-array packet from the host-side interface over a 4-phase handshake and validates the info byte. It then either loads a key into the core or presents one or two data blocks to the core over a second 4-phase handshake. The info byte and packet count are passed alongside so the output packer can rebuild the response packet.

## Interface
- N, `N (SIMON_defintions.svh), word width in bits; packet is 2+N/2 bytes
- MODE, `MODE, required value of info[3:0]
- clk  in  1  system clock, all state on rising edge
- nR  in  1  asynchronous active-low reset
- in_donePKT  in  1  upstream packet valid, held high until in_readPKT seen
- in  in  [(1+N/2):0][7:0]  packet: byte 1+N/2 = info, byte N/2 = count, low N/2 bytes = data[3:0][N-1:0]
- in_readPKT  out  1  packet accepted (4-phase ack)
- doneDATA  out  1  block valid to core
- readDATA  in  1  core accepted block, level, held until doneDATA falls
- inDATA  out  [1:0][N-1:0]  block words to core
- infoIN  out  [7:0]  latched info byte of current packet
- countIN  out  [7:0]  latched count byte of current packet
- keyDATA  out  [3:0][N-1:0]  key words
- loadKEY  out  1  one-cycle key-load strobe
- errPKT  out  1  one-cycle strobe: packet rejected
- errSEQ  out  1  one-cycle strobe: count byte ≠ expected sequence

## Operation
- Info byte: [3:0] mode; [4] direction (0 = input packet); [5] key packet; [6] word-swap; [7] two-block packet (ignored if [5]).
- States: WAIT, LOAD, KEY, SEND0, GAP, SEND1, ACK.
- WAIT: in_readPKT low. in_donePKT high → LOAD.
- LOAD: latch whole packet into infoIN, countIN and data regs, and set in_readPKT=1.
  - info[3:0]≠MODE or info[4]=1 → errPKT pulse, → ACK; nothing is driven to the core.
  - Otherwise, count byte ≠ expSEQ → errSEQ pulse, but processing continues. expSEQ is an 8-bit counter, resets to 0, increments mod 256 on every accepted (non-error) packet, and wraps 255→0.
  - info[5]=1 → KEY; else → SEND0.
- KEY: keyDATA ← data[3:0], loadKEY pulse, → ACK.
- SEND0: doneDATA=1 with base=0. Data mapping: inDATA[~info[6]]=data[base], inDATA[info[6]]=data[base+1].
  - readDATA high → doneDATA←0.
  - If info[7], → GAP; else → ACK.
- GAP: wait for readDATA low → SEND1.
- SEND1: same as SEND0 with base=2. readDATA high → doneDATA←0, → ACK.
- ACK: hold in_readPKT high until in_donePKT is low. Then require readDATA low, drop in_readPKT, → WAIT.
- A new packet is never latched while in_readPKT is high, so the input may change freely after the ack.
- inDATA and keyDATA hold their values between transfers. They are updated only on entry to SEND0/SEND1/KEY.

## Timing
- Reset (nR low, any state, mid-transfer included): state=WAIT, all outputs 0, expSEQ=0, data regs 0. No handshake is resumed after reset.
- in_donePKT sampled high at edge k: LOAD at k+1, in_readPKT high from k+1.
- Decision edges:
  - Key packet: loadKEY high at k+2, for exactly one cycle.
  - Data packet: doneDATA high from k+2.
- Core handshake: readDATA sampled high at edge j → doneDATA low after edge j+1.
- Second block: doneDATA re-asserts no earlier than 1 cycle after readDATA is sampled low.
- Minimum packet-to-packet spacing: 4 cycles (key) / 5 cycles (single block).
- errPKT and errSEQ are registered and one cycle wide, in the LOAD→next cycle.
- Simultaneous events:
  - readDATA high while in_donePKT is still high: both handshakes advance independently.
  - in_donePKT dropping before the block is consumed does not abort SEND; ACK waits for completion.

## Test plan
- Reset: drive nR low mid-SEND0 → next cycle doneDATA=0, in_readPKT=0, state WAIT; expSEQ back to 0.
- Key load: info=0x20|MODE, data={0x1918,0x1110,0x0908,0x0100} (N=16) → loadKEY one cycle, keyDATA equals data, doneDATA never asserted, in_readPKT 4-phase completes.
- Single block, info[6]=0: data[1:0]={0x6877,0x6565} → inDATA[1]=0x6565, inDATA[0]=0x6877. Same packet with info[6]=1 → words swapped. One doneDATA/readDATA cycle.
- Two-block: info[7]=1 → two doneDATA pulses, data[1:0] then data[3:2]. Second pulse is held off until readDATA falls. Stall readDATA for 10 cycles → doneDATA stays high and inDATA is stable.
- Errors: info[4]=1 → errPKT, no core activity, expSEQ unchanged. Mode≠MODE → errPKT. Count byte 5 when expSEQ=3 → errSEQ and the block is still delivered.
- Wrap: 257 valid packets → expSEQ wraps 255→0, no errSEQ with count bytes 0..255,0.

Source files
------------

// File: rtl/simon_data_in.sv
// Input packet unpacker for the SIMON core: accepts a host packet, validates the
// info byte, then either loads a key or hands one or two blocks to the core.
module simon_data_in #(
  parameter int         N    = 16,
  parameter logic [3:0] MODE = 4'h1
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  in_donePKT,
  input  logic [(1+N/2):0][7:0] in,
  output logic                  in_readPKT,
  output logic                  doneDATA,
  input  logic                  readDATA,
  output logic [1:0][N-1:0]     inDATA,
  output logic [7:0]            infoIN,
  output logic [7:0]            countIN,
  output logic [3:0][N-1:0]     keyDATA,
  output logic                  loadKEY,
  output logic                  errPKT,
  output logic                  errSEQ
);

  typedef enum logic [2:0] {WAIT, LOAD, KEY, SEND0, GAP, SEND1, ACK} state_t;

  state_t            state_q;
  logic [3:0][N-1:0] data_q;
  logic [7:0]        exp_seq_q;
  logic              pkt_bad;

  // Only input-direction packets of our own mode are accepted.
  assign pkt_bad = (infoIN[3:0] != MODE) || infoIN[4];

  // Word pair for one block; swap decides which output word gets the lower data word.
  function automatic logic [1:0][N-1:0] block(input logic [3:0][N-1:0] d,
                                              input logic hi, input logic swap);
    logic [1:0][N-1:0] b;
    b        = '0;
    b[~swap] = d[{hi, 1'b0}];
    b[swap]  = d[{hi, 1'b1}];
    return b;
  endfunction

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q    <= WAIT;
      data_q     <= '0;
      exp_seq_q  <= '0;
      in_readPKT <= 1'b0;
      doneDATA   <= 1'b0;
      inDATA     <= '0;
      infoIN     <= '0;
      countIN    <= '0;
      keyDATA    <= '0;
      loadKEY    <= 1'b0;
      errPKT     <= 1'b0;
      errSEQ     <= 1'b0;
    end else begin
      loadKEY <= 1'b0;
      errPKT  <= 1'b0;
      errSEQ  <= 1'b0;
      case (state_q)
        WAIT: begin
          if (in_donePKT) begin
            infoIN     <= in[1+N/2];
            countIN    <= in[N/2];
            data_q     <= in[N/2-1:0];
            in_readPKT <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (pkt_bad) begin
            errPKT  <= 1'b1;
            state_q <= ACK;
          end else begin
            // A sequence mismatch is only flagged; the packet is still processed.
            errSEQ    <= (countIN != exp_seq_q);
            exp_seq_q <= exp_seq_q + 8'd1;
            if (infoIN[5]) begin
              keyDATA <= data_q;
              loadKEY <= 1'b1;
              state_q <= KEY;
            end else begin
              inDATA   <= block(data_q, 1'b0, infoIN[6]);
              doneDATA <= 1'b1;
              state_q  <= SEND0;
            end
          end
        end
        KEY: state_q <= ACK;
        SEND0: begin
          if (readDATA) begin
            doneDATA <= 1'b0;
            state_q  <= infoIN[7] ? GAP : ACK;
          end
        end
        GAP: begin
          if (!readDATA) begin
            inDATA   <= block(data_q, 1'b1, infoIN[6]);
            doneDATA <= 1'b1;
            state_q  <= SEND1;
          end
        end
        SEND1: begin
          if (readDATA) begin
            doneDATA <= 1'b0;
            state_q  <= ACK;
          end
        end
        ACK: begin
          if (!in_donePKT && !readDATA) begin
            in_readPKT <= 1'b0;
            state_q    <= WAIT;
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end

endmodule
